// File: rtl/rom_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : rom_burst_reader_if
// Brief   : Request and beat-stream channels of the ROM burst reader.
// Revision: 1.0 - initial release
// ============================================================================
interface rom_burst_reader_if #(
    parameter int k = 8,
    parameter int m = 2
);
    logic         req_valid;
    logic         req_ready;
    logic [m-1:0] req_adr;
    logic [m-1:0] req_len;
    logic         out_valid;
    logic         out_ready;
    logic [k-1:0] data_out;
    logic [m-1:0] out_adr;
    logic         out_last;
    logic         out_err;

    modport master (
        output req_valid, req_adr, req_len, out_ready,
        input  req_ready, out_valid, data_out, out_adr, out_last, out_err
    );

    modport slave (
        input  req_valid, req_adr, req_len, out_ready,
        output req_ready, out_valid, data_out, out_adr, out_last, out_err
    );
endinterface
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : rom_burst_reader
// Brief   : Read-only lookup table streamed as wrapping bursts on valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module rom_burst_reader #(
    parameter int k         = 8,
    parameter int l         = 4,
    parameter int m         = 2,
    parameter int BASE      = 5,
    parameter     INIT_FILE = ""
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    rom_burst_reader_if.slave bus
);
    localparam int           c_span  = 1 << m;
    localparam logic [m:0]   c_depth = (m + 1)'(l);
    localparam logic [m-1:0] c_last  = m'(l - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Table spans the full address space so any m-bit index is legal; pad is zero.
    logic [k-1:0] w_rom [c_span];

    generate
        for (genvar gi = 0; gi < c_span; gi++) begin : g_word
            if (gi < l) begin : g_used
                assign w_rom[gi] = k'(BASE + gi);
            end else begin : g_pad
                assign w_rom[gi] = '0;
            end
        end
    endgenerate

    state_t       r_state;
    logic         r_req_ready;
    logic         r_out_valid;
    logic [k-1:0] r_data;
    logic [m-1:0] r_adr;
    logic         r_last;
    logic         r_err;
    logic [m-1:0] r_rem;

    logic         w_accept;
    logic         w_fire;
    logic         w_start_oor;
    logic [m-1:0] w_next_adr;

    assign w_accept    = bus.req_valid & r_req_ready;
    assign w_fire      = r_out_valid & bus.out_ready;
    assign w_start_oor = {1'b0, bus.req_adr} >= c_depth;
    assign w_next_adr  = (r_adr == c_last) ? '0 : r_adr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_adr       <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_rem       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_state     <= BURST;
                        r_req_ready <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_adr       <= bus.req_adr;
                        // An out-of-range start collapses to a single error beat.
                        if (w_start_oor) begin
                            r_data <= '0;
                            r_err  <= 1'b1;
                            r_last <= 1'b1;
                            r_rem  <= '0;
                        end else begin
                            r_data <= w_rom[bus.req_adr];
                            r_err  <= 1'b0;
                            r_last <= (bus.req_len == '0);
                            r_rem  <= bus.req_len;
                        end
                    end
                end
                BURST: begin
                    if (w_fire) begin
                        if (r_last) begin
                            r_state     <= IDLE;
                            r_out_valid <= 1'b0;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_adr  <= w_next_adr;
                            r_data <= w_rom[w_next_adr];
                            r_rem  <= r_rem - 1'b1;
                            r_last <= (r_rem == m'(1));
                        end
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data;
    assign bus.out_adr   = r_adr;
    assign bus.out_last  = r_last;
    assign bus.out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_rom_burst_reader
// Brief   : Self-checking bench for a default and a depth-6 rom_burst_reader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rom_burst_reader;
    typedef struct {
        logic [7:0] data;
        logic [2:0] adr;
        logic       last;
        logic       err;
    } beat_t;

    typedef struct {
        int d;
        int adr;
        int len;
        int stall;
        int exp_first;
        int exp_beats;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] req_valid;
    logic [1:0] out_ready;
    logic [2:0] req_adr [2];
    logic [2:0] req_len [2];
    logic [1:0] rdy;
    logic [1:0] vld;
    logic [1:0] lst;
    logic [1:0] err;
    logic [7:0] dat [2];
    logic [2:0] oadr [2];

    rom_burst_reader_if #(.k(8), .m(2)) if0 ();
    rom_burst_reader_if #(.k(8), .m(3)) if1 ();

    assign if0.req_valid = req_valid[0];
    assign if0.req_adr   = req_adr[0][1:0];
    assign if0.req_len   = req_len[0][1:0];
    assign if0.out_ready = out_ready[0];
    assign rdy[0]        = if0.req_ready;
    assign vld[0]        = if0.out_valid;
    assign lst[0]        = if0.out_last;
    assign err[0]        = if0.out_err;
    assign dat[0]        = if0.data_out;
    assign oadr[0]       = {1'b0, if0.out_adr};

    assign if1.req_valid = req_valid[1];
    assign if1.req_adr   = req_adr[1];
    assign if1.req_len   = req_len[1];
    assign if1.out_ready = out_ready[1];
    assign rdy[1]        = if1.req_ready;
    assign vld[1]        = if1.out_valid;
    assign lst[1]        = if1.out_last;
    assign err[1]        = if1.out_err;
    assign dat[1]        = if1.data_out;
    assign oadr[1]       = if1.out_adr;

    rom_burst_reader #(.k(8), .l(4), .m(2), .BASE(5)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    rom_burst_reader #(.k(8), .l(6), .m(3), .BASE(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    beat_t      q0[$];
    beat_t      q1[$];
    int         checks = 0;
    int         failures = 0;
    int         hs_cnt [2] = '{0, 0};
    int         mark [2] = '{0, 0};
    logic [7:0] first_dat [2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] outs(int d);
        return 32'({rdy[d], vld[d], lst[d], err[d], dat[d], oadr[d]});
    endfunction

    // Reference: word i = BASE + i, wrap at depth, out-of-range start -> one error beat.
    function automatic void push_model(int d, int adr, int len);
        int    depth = (d == 0) ? 4 : 6;
        int    base  = (d == 0) ? 5 : 16;
        int    a     = adr;
        beat_t b;
        if (adr >= depth) begin
            b.data = 8'h00; b.adr = 3'(adr); b.last = 1'b1; b.err = 1'b1;
            if (d == 0) q0.push_back(b); else q1.push_back(b);
        end else begin
            for (int i = 0; i <= len; i++) begin
                b.data = 8'(base + a); b.adr = 3'(a); b.last = (i == len); b.err = 1'b0;
                if (d == 0) q0.push_back(b); else q1.push_back(b);
                a = (a == depth - 1) ? 0 : a + 1;
            end
        end
    endfunction

    // Scores handshakes seen before the edge, then advances one clock.
    task automatic tick();
        logic [1:0] acc;
        beat_t      e;
        for (int d = 0; d < 2; d++) begin
            acc[d] = req_valid[d] & rdy[d];
            if (vld[d] && out_ready[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat d%0d: got data 0x%0h expected no beat", d, dat[d]);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("beat d%0d {data,adr,last,err}", d),
                          32'({dat[d], oadr[d], lst[d], err[d]}),
                          32'({e.data, e.adr, e.last, e.err}));
                end
                if (hs_cnt[d] == mark[d]) first_dat[d] = dat[d];
                hs_cnt[d]++;
            end
            if (acc[d]) push_model(d, int'(req_adr[d]), int'(req_len[d]));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) if (acc[d]) req_valid[d] = 1'b0;
    endtask

    task automatic request(int d, int adr, int len);
        int cyc = 0;
        req_adr[d]   = 3'(adr);
        req_len[d]   = 3'(len);
        req_valid[d] = 1'b1;
        while (req_valid[d] && cyc < 20) begin
            tick();
            cyc++;
        end
        check($sformatf("accept d%0d pending", d), 32'(req_valid[d]), 32'd0);
        req_valid[d] = 1'b0;
    endtask

    task automatic run_vec(vec_t v);
        int         d = v.d;
        int         cyc = 0;
        logic [31:0] snap;
        mark[d]      = hs_cnt[d];
        out_ready[d] = 1'b0;
        request(d, v.adr, v.len);
        check($sformatf("valid after accept d%0d", d), 32'(vld[d]), 32'd1);
        snap = outs(d);
        for (int i = 0; i < v.stall; i++) begin
            tick();
            check($sformatf("stall hold d%0d", d), outs(d), snap);
        end
        out_ready[d] = 1'b1;
        while (vld[d] && cyc < 40) begin
            tick();
            cyc++;
        end
        out_ready[d] = 1'b0;
        check($sformatf("burst cycles d%0d adr%0d", d, v.adr), 32'(cyc), 32'(v.exp_beats));
        check($sformatf("beat count d%0d adr%0d", d, v.adr), 32'(hs_cnt[d] - mark[d]), 32'(v.exp_beats));
        check($sformatf("first data d%0d adr%0d", d, v.adr), 32'(first_dat[d]), 32'(v.exp_first));
        check($sformatf("req_ready after last d%0d", d), 32'(rdy[d]), 32'd1);
    endtask

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 2, 3, 0,  7, 4};
        tbl[1] = '{0, 0, 1, 3,  5, 2};
        tbl[2] = '{0, 3, 3, 0,  8, 4};
        tbl[3] = '{0, 1, 2, 1,  6, 3};
        tbl[4] = '{1, 5, 2, 0, 21, 3};
        tbl[5] = '{1, 7, 4, 0,  0, 1};
        tbl[6] = '{1, 6, 0, 2,  0, 1};
        tbl[7] = '{1, 0, 7, 0, 16, 8};

        req_valid = '0;
        out_ready = '0;
        for (int d = 0; d < 2; d++) begin
            req_adr[d] = '0;
            req_len[d] = '0;
        end

        #12;
        check("reset outputs d0", outs(0), 32'd0);
        check("reset outputs d1", outs(1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("req_ready before first edge", 32'(rdy), 32'd0);
        @(posedge clk);
        #1;
        check("req_ready after first edge", 32'(rdy), 32'd3);

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset asserted mid-cycle while the third beat of a burst is pending.
        mark[0] = hs_cnt[0];
        request(0, 0, 3);
        out_ready[0] = 1'b1;
        tick();
        tick();
        check("beats before reset", 32'(hs_cnt[0] - mark[0]), 32'd2);
        check("valid before reset", 32'(vld[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset d0", outs(0), 32'd0);
        check("async reset d1", outs(1), 32'd0);
        q0.delete();
        out_ready[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready after mid-burst reset", 32'(rdy), 32'd3);
        run_vec('{0, 3, 0, 0, 8, 1});

        check("scoreboard empty d0", 32'(q0.size()), 32'd0);
        check("scoreboard empty d1", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
